pe_tile_sequencer: RTL and testbench

//   Drives PE_array from on-chip ifmap/weight/bias buffers, the RTL counterpart of the PE_array stimulus side.
//   Per tile: fetches BLOCK_W k-slices, pulses pe_en, waits for pe_valid, captures BLOCK_H opsums.

---
 rtl/pe_tile_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_pe_tile_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_tile_sequencer.sv
// pe_tile_sequencer
//   Feeds PE_array from the ifmap/weight/bias buffers one tile at a time,
//   captures the BLOCK_H opsums it returns and streams them out over a
//   valid/ready port. Runs num_tiles tiles per start pulse.
//
//   Ports
//     clk, rst                    clock (rising edge), async active-low reset
//     start, num_tiles            run request (latched in IDLE only)
//     busy, done                  run status; done pulses once per run
//     ifm_/wgt_/bias_rd_addr/data buffer read ports, 1-cycle read latency
//     pe_ifmap, pe_weight         pass-through of buffer read data
//     pe_bias                     bias row block, loaded in the k=0 feed cycle
//     pe_en                       marks the k=0 feed cycle
//     pe_valid, pe_ofmap          PE_array result handshake
//     out_data/out_idx/out_valid/out_ready  opsum stream
//
//   Build option: SEQ_RELU_EN clamps negative captured opsums to zero.

module pe_seq_cap_row #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [ACC_W-1:0] d,
    output logic [ACC_W-1:0] q
);
    logic [ACC_W-1:0] d_mod;

`ifdef SEQ_RELU_EN
    assign d_mod = d[ACC_W-1] ? '0 : d;
`else
    assign d_mod = d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= '0;
        else if (ld) q <= d_mod;
    end
endmodule

module pe_tile_sequencer #(
    parameter int DATA_SIZE  = 8,
    parameter int ACC_W      = 32,
    parameter int BLOCK_W    = 4,
    parameter int BLOCK_H    = 8,
    parameter int ARRAY_SIZE = 8,
    parameter int ADDR_W     = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [ADDR_W-1:0]                     num_tiles,
    output logic                                  busy,
    output logic                                  done,
    output logic [ADDR_W-1:0]                     ifm_rd_addr,
    input  logic [ARRAY_SIZE*DATA_SIZE-1:0]         ifm_rd_data,
    output logic [ADDR_W-1:0]                     wgt_rd_addr,
    input  logic [BLOCK_H*ARRAY_SIZE*DATA_SIZE-1:0] wgt_rd_data,
    output logic [ADDR_W-1:0]                     bias_rd_addr,
    input  logic [BLOCK_H*ACC_W-1:0]              bias_rd_data,
    output logic [ARRAY_SIZE*DATA_SIZE-1:0]         pe_ifmap,
    output logic [BLOCK_H*ARRAY_SIZE*DATA_SIZE-1:0] pe_weight,
    output logic [BLOCK_H*ACC_W-1:0]              pe_bias,
    output logic                                  pe_en,
    input  logic                                  pe_valid,
    input  logic [BLOCK_H*ACC_W-1:0]              pe_ofmap,
    output logic [ACC_W-1:0]                      out_data,
    output logic [$clog2(BLOCK_H)-1:0]            out_idx,
    output logic                                  out_valid,
    input  logic                                  out_ready
);
    localparam int KW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
    localparam int IW = $clog2(BLOCK_H);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FEED, S_WAIT, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] tile_q, tile_d, ntiles_q, ntiles_d;
    logic [ADDR_W-1:0] addr_q, addr_d, baddr_q, baddr_d;
    logic [KW-1:0]     k_q, k_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              done_d, bias_ld, cap_ld;
    logic [ADDR_W-1:0] tile_nx, base, base_nx;

    logic [BLOCK_H-1:0][ACC_W-1:0] ofmap_rows, cap_rows;

    // Buffer address = tile*BLOCK_W + k, wrapping at ADDR_W bits.
    assign tile_nx = tile_q + 1'b1;
    assign base    = tile_q << KW;
    assign base_nx = tile_nx << KW;

    always_comb begin
        state_d  = state_q;
        tile_d   = tile_q;
        ntiles_d = ntiles_q;
        addr_d   = addr_q;
        baddr_d  = baddr_q;
        k_d      = k_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        bias_ld  = 1'b0;
        cap_ld   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_tiles != '0) begin
                        state_d  = S_FETCH;
                        ntiles_d = num_tiles;
                        tile_d   = '0;
                        addr_d   = '0;
                        baddr_d  = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            // Address for k=0 is already on the bus; hold it until the
            // array has dropped its previous result.
            S_FETCH: begin
                if (!pe_valid) begin
                    state_d = S_FEED;
                    k_d     = '0;
                    addr_d  = base + ADDR_W'(1);
                end
            end
            S_FEED: begin
                bias_ld = (k_q == '0);
                if (k_q == KW'(BLOCK_W - 1)) begin
                    state_d = S_WAIT;
                end else begin
                    k_d    = k_q + 1'b1;
                    addr_d = base + ADDR_W'(k_q) + ADDR_W'(2);
                end
            end
            S_WAIT: begin
                if (pe_valid) begin
                    cap_ld  = 1'b1;
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (idx_q == IW'(BLOCK_H - 1)) begin
                        idx_d  = '0;
                        tile_d = tile_nx;
                        if (tile_q == ntiles_q - 1'b1) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                            addr_d  = base_nx;
                            baddr_d = tile_nx;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            tile_q   <= '0;
            ntiles_q <= '0;
            addr_q   <= '0;
            baddr_q  <= '0;
            k_q      <= '0;
            idx_q    <= '0;
            done     <= 1'b0;
            pe_bias  <= '0;
        end else begin
            state_q  <= state_d;
            tile_q   <= tile_d;
            ntiles_q <= ntiles_d;
            addr_q   <= addr_d;
            baddr_q  <= baddr_d;
            k_q      <= k_d;
            idx_q    <= idx_d;
            done     <= done_d;
            if (bias_ld) pe_bias <= bias_rd_data;
        end
    end

    assign ofmap_rows = pe_ofmap;

    for (genvar h = 0; h < BLOCK_H; h++) begin : g_cap
        pe_seq_cap_row #(.ACC_W(ACC_W)) u_row (
            .clk (clk),
            .rst (rst),
            .ld  (cap_ld),
            .d   (ofmap_rows[h]),
            .q   (cap_rows[h])
        );
    end

    assign busy         = (state_q != S_IDLE);
    assign pe_en        = (state_q == S_FEED) && (k_q == '0);
    assign out_valid    = (state_q == S_DRAIN);
    assign out_idx      = idx_q;
    assign out_data     = cap_rows[idx_q];
    assign ifm_rd_addr  = addr_q;
    assign wgt_rd_addr  = addr_q;
    assign bias_rd_addr = baddr_q;
    assign pe_ifmap     = ifm_rd_data;
    assign pe_weight    = wgt_rd_data;
endmodule

// File: tb/tb_pe_tile_sequencer.sv
module tb_pe_tile_sequencer;
    localparam int DS = 8, AW = 32, BW = 4, BH = 8, AS = 8, ADW = 10;

    logic                clk = 0, rst = 0, start = 0, out_ready = 1;
    logic [ADW-1:0]      num_tiles = '0;
    logic                busy, done, pe_en, pe_valid, out_valid;
    logic [ADW-1:0]      ifm_rd_addr, wgt_rd_addr, bias_rd_addr;
    logic [AS*DS-1:0]    ifm_rd_data, pe_ifmap;
    logic [BH*AS*DS-1:0] wgt_rd_data, pe_weight;
    logic [BH*AW-1:0]    bias_rd_data, pe_bias, pe_ofmap;
    logic [AW-1:0]       out_data;
    logic [2:0]          out_idx;

    pe_tile_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
        .busy(busy), .done(done),
        .ifm_rd_addr(ifm_rd_addr), .ifm_rd_data(ifm_rd_data),
        .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
        .pe_ifmap(pe_ifmap), .pe_weight(pe_weight), .pe_bias(pe_bias),
        .pe_en(pe_en), .pe_valid(pe_valid), .pe_ofmap(pe_ofmap),
        .out_data(out_data), .out_idx(out_idx),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    logic [AS*DS-1:0]    ifm_mem  [1024];
    logic [BH*AS*DS-1:0] wgt_mem  [1024];
    logic [BH*AW-1:0]    bias_mem [1024];

    always @(posedge clk) begin
        ifm_rd_data  <= ifm_mem[ifm_rd_addr];
        wgt_rd_data  <= wgt_mem[wgt_rd_addr];
        bias_rd_data <= bias_mem[bias_rd_addr];
    end

    int n_cmp = 0, n_err = 0;
    int done_cnt = 0, en_cnt = 0;
    int ready_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct { logic [31:0] d; logic [2:0] i; } exp_t;
    exp_t q[$];

    function automatic logic [31:0] exp_word(input int t, input int h);
        logic [31:0] acc;
        logic [ADW-1:0] a;
        acc = bias_mem[t][h*AW +: AW];
        for (int k = 0; k < BW; k++) begin
            a = ADW'(t * BW + k);
            for (int g = 0; g < AS; g++)
                acc += 32'(ifm_mem[a][g*DS +: DS]) * 32'(wgt_mem[a][(g*BH+h)*DS +: DS]);
        end
`ifdef SEQ_RELU_EN
        if (acc[31]) acc = 32'h0;
`endif
        return acc;
    endfunction

    // Memory images: tile 3 has zero ifmap so its opsums equal the bias,
    // and row 5 of that bias is negative.
    initial begin
        for (int a = 0; a < 1024; a++) begin
            for (int g = 0; g < AS; g++)
                ifm_mem[a][g*DS +: DS] = (a >= 12 && a < 16) ? 8'h0 : 8'((a*3 + g + 1) & 8'hff);
            for (int e = 0; e < AS*BH; e++)
                wgt_mem[a][e*DS +: DS] = 8'((a + (e / BH) + 2*(e % BH)) & 4'hf);
            for (int h = 0; h < BH; h++)
                bias_mem[a][h*AW +: AW] = 32'(a*100 + h);
        end
        bias_mem[3][5*AW +: AW] = 32'hFFFFFF00;
    end

    // out_ready driver, changed just after the rising edge.
    initial forever begin
        @(posedge clk); #1;
        out_ready = (ready_mode == 1) ? ~out_ready : 1'b1;
    end

    // Behavioural PE_array: accumulates the BLOCK_W feed cycles that follow
    // pe_en, adds pe_bias, then returns one pe_valid pulse.
    initial begin
        logic [31:0] acc [BH];
        logic        en_bad;
        pe_valid = 0;
        pe_ofmap = '0;
        forever begin
            @(negedge clk);
            if (pe_en) begin
                en_cnt++;
                en_bad = 0;
                for (int h = 0; h < BH; h++) acc[h] = 0;
                for (int k = 0; k < BW; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        if (pe_en) en_bad = 1;
                    end
                    for (int g = 0; g < AS; g++)
                        for (int h = 0; h < BH; h++)
                            acc[h] += 32'(pe_ifmap[g*DS +: DS]) * 32'(pe_weight[(g*BH+h)*DS +: DS]);
                end
                chk("pe_en_single_pulse", {31'b0, en_bad}, 32'd0);
                repeat (2) @(negedge clk);
                for (int h = 0; h < BH; h++)
                    pe_ofmap[h*AW +: AW] = acc[h] + pe_bias[h*AW +: AW];
                pe_valid = 1;
                @(negedge clk);
                pe_valid = 0;
                pe_ofmap = '1;
            end
        end
    end

    // Monitor: pops an expected word on every accepted beat and checks
    // that a stalled beat holds its value.
    initial begin
        exp_t        e;
        logic        stalled = 0;
        logic [31:0] s_d;
        logic [2:0]  s_i;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!rst) stalled = 0;
            else if (out_valid) begin
                if (stalled) begin
                    chk("stall_data_stable", out_data, s_d);
                    chk("stall_idx_stable", {29'b0, out_idx}, {29'b0, s_i});
                end
                if (out_ready) begin
                    stalled = 0;
                    if (q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL extra_word: got %h idx %0d expected none", out_data, out_idx);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_idx", {29'b0, out_idx}, {29'b0, e.i});
                    end
                end else begin
                    stalled = 1; s_d = out_data; s_i = out_idx;
                end
            end
        end
    end

    task automatic push_tiles(input int n);
        exp_t e;
        for (int t = 0; t < n; t++)
            for (int h = 0; h < BH; h++) begin
                e.d = exp_word(t, h); e.i = 3'(h); q.push_back(e);
            end
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        num_tiles = ADW'(n); start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic run(input int n, input int mode, input bit disturb);
        int d0, e0, cyc;
        d0 = done_cnt; e0 = en_cnt;
        ready_mode = mode;
        push_tiles(n);
        pulse_start(n);
        if (disturb) begin
            repeat (4) @(negedge clk);
            num_tiles = 10'd7; start = 1;
            @(negedge clk);
            start = 0;
        end
        cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin @(negedge clk); cyc++; end
        chk("run_done_seen", {31'b0, done_cnt != d0}, 32'd1);
        chk("busy_low_with_done", {31'b0, busy}, 32'd0);
        repeat (10) @(negedge clk);
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("pe_en_count", 32'(en_cnt - e0), 32'(n));
        chk("queue_drained", 32'(q.size()), 32'd0);
        ready_mode = 0;
    endtask

    initial begin
        int cyc, e0;
        logic ever_busy;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_pe_en", {31'b0, pe_en}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_idx", {29'b0, out_idx}, 32'd0);
        chk("rst_pe_bias", pe_bias[31:0], 32'd0);
        chk("rst_ifm_addr", {22'b0, ifm_rd_addr}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1;

        // Zero-tile start: done one cycle later, never busy, no reads.
        ever_busy = 0;
        @(negedge clk);
        num_tiles = '0; start = 1;
        @(negedge clk);
        start = 0;
        chk("zero_done_pulse", {31'b0, done}, 32'd1);
        ever_busy |= busy;
        @(negedge clk);
        chk("zero_done_drop", {31'b0, done}, 32'd0);
        repeat (3) begin ever_busy |= busy; @(negedge clk); end
        chk("zero_never_busy", {31'b0, ever_busy}, 32'd0);
        chk("zero_no_ifm_addr", {22'b0, ifm_rd_addr}, 32'd0);
        chk("zero_no_bias_addr", {22'b0, bias_rd_addr}, 32'd0);

        run(1, 0, 0);
        run(2, 0, 1);
        run(4, 1, 0);

        // Reset during tile 1 feed: only tile 0 words are expected.
        e0 = en_cnt;
        push_tiles(1);
        pulse_start(2);
        cyc = 0;
        while (en_cnt < e0 + 2 && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("rst_mid_reached_tile1", {31'b0, en_cnt >= e0 + 2}, 32'd1);
        rst = 0;
        #1;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_pe_en", {31'b0, pe_en}, 32'd0);
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_queue", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1;
        repeat (30) @(negedge clk);
        run(1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
